// File: rtl/branch_pred_pc_unit.sv
// Fetch PC register with next-PC selection, a 2-bit-counter BHT predicting in ID,
// branch resolution/redirect from EX, and branch/mispredict performance counters.
module branch_pred_pc_unit #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_2000,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  output logic [PC_WIDTH-1:0]  pc,
  input  logic                 id_valid,
  input  logic                 id_is_branch,
  input  logic                 id_is_jal,
  input  logic [PC_WIDTH-1:0]  id_pc,
  input  logic [PC_WIDTH-1:0]  id_target,
  output logic                 id_pred_taken,
  input  logic                 ex_valid,
  input  logic                 ex_is_branch,
  input  logic                 ex_is_jalr,
  input  logic [2:0]           ex_funct3,
  input  logic                 ex_BrEq,
  input  logic                 ex_BrLt,
  input  logic                 ex_pred_taken,
  input  logic [PC_WIDTH-1:0]  ex_pc,
  input  logic [PC_WIDTH-1:0]  ex_target,
  output logic [1:0]           PCSel,
  output logic                 flush_if_id,
  output logic                 flush_id_ex,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic [1:0] {
    SEL_PC4  = 2'b00,
    SEL_ID   = 2'b01,
    SEL_EX   = 2'b10,
    SEL_HOLD = 2'b11
  } pcsel_e;

  logic [1:0]          bht [BHT_ENTRIES];
  logic [IDX_W-1:0]    id_idx;
  logic [IDX_W-1:0]    ex_idx;
  logic                ex_taken;
  logic                ex_br;
  logic                mispred;
  logic                ex_redirect;
  logic                id_redirect;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] ex_redirect_pc;
  logic [PC_WIDTH-1:0] pc_next;
  pcsel_e              sel;

  logic unused_id_pc_bits;
  assign unused_id_pc_bits = ^{id_pc[PC_WIDTH-1:IDX_W+2], id_pc[1:0]};

  assign id_idx = id_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  assign id_pred_taken = id_valid & id_is_branch & bht[id_idx][1];

  always_comb begin
    ex_taken = 1'b0;
    unique case (ex_funct3)
      3'b000:         ex_taken = ex_BrEq;
      3'b001:         ex_taken = ~ex_BrEq;
      3'b100, 3'b110: ex_taken = ex_BrLt;
      3'b101, 3'b111: ex_taken = ~ex_BrLt;
      default:        ex_taken = 1'b0;
    endcase
  end

  assign ex_br       = ex_valid & ex_is_branch;
  assign mispred     = ex_br & (ex_taken != ex_pred_taken);
  assign ex_redirect = mispred | (ex_valid & ex_is_jalr);
  assign id_redirect = id_valid & (id_is_jal | id_pred_taken) & ~stall & ~ex_redirect;
  assign pc_plus4    = pc + PC_WIDTH'(4);

  always_comb begin
    ex_redirect_pc = ex_pc + PC_WIDTH'(4);
    if (ex_valid && ex_is_jalr) ex_redirect_pc = {ex_target[PC_WIDTH-1:1], 1'b0};
    else if (ex_taken)          ex_redirect_pc = ex_target;
  end

  // EX redirect wins even over stall; stall then blocks any ID redirect.
  always_comb begin
    sel     = SEL_PC4;
    pc_next = pc_plus4;
    if (ex_redirect) begin
      sel     = SEL_EX;
      pc_next = ex_redirect_pc;
    end else if (stall) begin
      sel     = SEL_HOLD;
      pc_next = pc;
    end else if (id_redirect) begin
      sel     = SEL_ID;
      pc_next = id_target;
    end
  end

  assign PCSel       = sel;
  assign flush_if_id = ex_redirect | id_redirect;
  assign flush_id_ex = ex_redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pc_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (ex_br) begin
      if (ex_taken && bht[ex_idx] != 2'b11)       bht[ex_idx] <= bht[ex_idx] + 2'd1;
      else if (!ex_taken && bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (ex_br)   branch_cnt  <= branch_cnt + CNT_WIDTH'(1);
      if (mispred) mispred_cnt <= mispred_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_branch_pred_pc_unit.sv
// Scoreboard bench for branch_pred_pc_unit: a reference model queues expected
// outputs per driven cycle; they are popped and compared as the DUT responds.
module tb_branch_pred_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [31:0] pc;
  logic        id_valid, id_is_branch, id_is_jal;
  logic [31:0] id_pc, id_target;
  logic        id_pred_taken;
  logic        ex_valid, ex_is_branch, ex_is_jalr;
  logic [2:0]  ex_funct3;
  logic        ex_BrEq, ex_BrLt, ex_pred_taken;
  logic [31:0] ex_pc, ex_target;
  logic [1:0]  PCSel;
  logic        flush_if_id, flush_id_ex;
  logic [31:0] branch_cnt, mispred_cnt;

  always #5 clk = ~clk;

  branch_pred_pc_unit #(
    .PC_WIDTH(32), .BHT_ENTRIES(64), .RESET_PC(32'h0000_2000), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pc(pc),
    .id_valid(id_valid), .id_is_branch(id_is_branch), .id_is_jal(id_is_jal),
    .id_pc(id_pc), .id_target(id_target), .id_pred_taken(id_pred_taken),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jalr(ex_is_jalr),
    .ex_funct3(ex_funct3), .ex_BrEq(ex_BrEq), .ex_BrLt(ex_BrLt),
    .ex_pred_taken(ex_pred_taken), .ex_pc(ex_pc), .ex_target(ex_target),
    .PCSel(PCSel), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  typedef struct packed {
    logic        pred;
    logic [1:0]  sel;
    logic        fif;
    logic        fie;
    logic [31:0] pc;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_pc, m_bc, m_mc;
  logic [1:0]  m_bht [64];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h2000; m_bc = '0; m_mc = '0;
    for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
  endtask

  task automatic idle();
    stall = 0; id_valid = 0; id_is_branch = 0; id_is_jal = 0; id_pc = '0; id_target = '0;
    ex_valid = 0; ex_is_branch = 0; ex_is_jalr = 0; ex_funct3 = '0; ex_BrEq = 0; ex_BrLt = 0;
    ex_pred_taken = 0; ex_pc = '0; ex_target = '0;
  endtask

  // One clock: model predicts, pushes expectations, then pops and compares.
  task automatic step();
    exp_t e, g;
    logic [5:0] ii, ei;
    logic tk, br, mp, exr, idr;
    ii = id_pc[7:2];
    ei = ex_pc[7:2];
    case (ex_funct3)
      3'b000: tk = ex_BrEq;
      3'b001: tk = !ex_BrEq;
      3'b100, 3'b110: tk = ex_BrLt;
      3'b101, 3'b111: tk = !ex_BrLt;
      default: tk = 1'b0;
    endcase
    br  = ex_valid & ex_is_branch;
    mp  = br & (tk != ex_pred_taken);
    exr = mp | (ex_valid & ex_is_jalr);
    e.pred = id_valid & id_is_branch & m_bht[ii][1];
    idr = id_valid & (id_is_jal | e.pred) & !stall & !exr;
    if (exr) begin
      e.sel = 2'b10;
      e.pc  = (ex_valid & ex_is_jalr) ? {ex_target[31:1], 1'b0} : (tk ? ex_target : ex_pc + 32'd4);
    end else if (stall) begin
      e.sel = 2'b11; e.pc = m_pc;
    end else if (idr) begin
      e.sel = 2'b01; e.pc = id_target;
    end else begin
      e.sel = 2'b00; e.pc = m_pc + 32'd4;
    end
    e.fif = exr | idr;
    e.fie = exr;
    e.bc  = m_bc + (br ? 32'd1 : 32'd0);
    e.mc  = m_mc + (mp ? 32'd1 : 32'd0);
    sb.push_back(e);
    #2;
    g = sb.pop_front();
    check("id_pred_taken", {31'b0, id_pred_taken}, {31'b0, g.pred});
    check("PCSel", {30'b0, PCSel}, {30'b0, g.sel});
    check("flush_if_id", {31'b0, flush_if_id}, {31'b0, g.fif});
    check("flush_id_ex", {31'b0, flush_id_ex}, {31'b0, g.fie});
    if (br) begin
      if (tk && m_bht[ei] != 2'b11) m_bht[ei] = m_bht[ei] + 2'd1;
      else if (!tk && m_bht[ei] != 2'b00) m_bht[ei] = m_bht[ei] - 2'd1;
    end
    @(posedge clk);
    #1;
    check("pc", pc, g.pc);
    check("branch_cnt", branch_cnt, g.bc);
    check("mispred_cnt", mispred_cnt, g.mc);
    m_pc = g.pc; m_bc = g.bc; m_mc = g.mc;
  endtask

  task automatic ex_branch(input logic [31:0] p, input logic [2:0] f3, input logic eq,
                           input logic lt, input logic pr, input logic [31:0] tgt);
    ex_valid = 1; ex_is_branch = 1; ex_pc = p; ex_funct3 = f3;
    ex_BrEq = eq; ex_BrLt = lt; ex_pred_taken = pr; ex_target = tgt;
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 0;
    #12;
    check("reset_pc", pc, 32'h2000);
    check("reset_bcnt", branch_cnt, 32'd0);
    rst_n = 1;
    for (int i = 0; i < 3; i++) step();

    // Mid-run reset with a predicted BNE in ID sitting on a fresh 01 entry.
    ex_branch(32'h2010, 3'b000, 1, 0, 0, 32'h2100);
    step();
    idle();
    rst_n = 0;
    id_valid = 1; id_is_branch = 1; id_pc = 32'h2008; id_target = 32'h2400;
    #1;
    model_reset();
    check("rst_pc", pc, 32'h2000);
    check("rst_mcnt", mispred_cnt, 32'd0);
    check("rst_pred", {31'b0, id_pred_taken}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    step();
    idle();

    // Training: two taken BEQ resolutions saturate the entry.
    ex_branch(32'h2010, 3'b000, 1, 0, 0, 32'h2100);
    step();
    check("train1_pc", pc, 32'h2100);
    check("train1_mcnt", mispred_cnt, 32'd1);
    step();
    check("train2_mcnt", mispred_cnt, 32'd2);
    idle();
    id_valid = 1; id_is_branch = 1; id_pc = 32'h2010; id_target = 32'h2100;
    step();
    check("train_id_pc", pc, 32'h2100);
    idle();

    // Saturation at 00 with BGE not taken.
    for (int i = 0; i < 5; i++) begin
      ex_branch(32'h2080, 3'b101, 0, 1, 0, 32'h2200);
      step();
    end
    check("sat_bcnt", branch_cnt, 32'd7);
    ex_branch(32'h2080, 3'b000, 0, 0, 0, 32'h2200);
    id_valid = 1; id_is_branch = 1; id_pc = 32'h2080; id_target = 32'h2200;
    step();
    idle();
    ex_branch(32'h2080, 3'b000, 1, 0, 0, 32'h2200);
    step();
    idle();
    id_valid = 1; id_is_branch = 1; id_pc = 32'h2080;
    step();
    idle();

    // JALR vs JAL vs stall in the same cycle.
    ex_valid = 1; ex_is_jalr = 1; ex_target = 32'h3001; ex_pc = 32'h2050;
    id_valid = 1; id_is_jal = 1; id_target = 32'h4000; stall = 1;
    step();
    check("prio_pc", pc, 32'h3000);
    idle();
    stall = 1;
    step();
    idle();

    // Mispredicted taken branch falls through to ex_pc + 4.
    ex_branch(32'h2040, 3'b000, 0, 0, 1, 32'h2800);
    step();
    check("mispt_pc", pc, 32'h2044);
    idle();

    // Same-index read/update collision, and funct3 = 010 treated as not taken.
    ex_branch(32'h20C0, 3'b000, 1, 0, 0, 32'h2500);
    id_valid = 1; id_is_branch = 1; id_pc = 32'h20C0; id_target = 32'h2500;
    step();
    ex_branch(32'h20C0, 3'b010, 1, 1, 0, 32'h2500);
    step();
    idle();

    // PC+4 wrap from all-ones.
    id_valid = 1; id_is_jal = 1; id_target = 32'hFFFF_FFFF;
    step();
    idle();
    step();
    check("wrap_pc", pc, 32'h3);

    // Random mix of ID/EX traffic.
    for (int i = 0; i < 60; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      id_valid = $urandom_range(0, 1); id_is_branch = $urandom_range(0, 1);
      id_is_jal = ($urandom_range(0, 4) == 0);
      id_pc = 32'h2000 + ($urandom_range(0, 15) << 2); id_target = $urandom;
      ex_valid = $urandom_range(0, 1); ex_is_branch = $urandom_range(0, 1);
      ex_is_jalr = ($urandom_range(0, 5) == 0);
      ex_funct3 = 3'($urandom_range(0, 7)); ex_BrEq = $urandom_range(0, 1);
      ex_BrLt = $urandom_range(0, 1); ex_pred_taken = $urandom_range(0, 1);
      ex_pc = 32'h2000 + ($urandom_range(0, 15) << 2); ex_target = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
